spi_rx_word_reader: RTL and testbench

Sequencer directly downstream of the byte-level SPI receiver. It issues one-cycle read requests to the receiver and collects the returned bytes. It packs them MSB-first into WORD_BYTES-wide words and delivers a programmed number of words over a valid/ready stream. Backpressure is honoured by stalling byte requests, so no byte is ever dropped.

---
 rtl/spi_rx_word_reader.sv | 138 +++++++++++++
 tb/tb_spi_rx_word_reader.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_rx_word_reader.sv
// Requests bytes from an SPI byte receiver one at a time, packs them MSB-first
// into words and streams a programmed number of words out over valid/ready.
module spi_rx_word_reader #(
   parameter int unsigned WORD_BYTES = 2,
   parameter int unsigned LEN_W      = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic [LEN_W-1:0]        length,
   output logic                    busy,
   output logic                    done,
   output logic                    rx_rd_en,
   input  logic [7:0]              rx_data,
   input  logic                    rx_received,
   output logic [WORD_BYTES*8-1:0] word_data,
   output logic                    word_valid,
   input  logic                    word_ready
);

   localparam int unsigned CNT_W = $clog2(WORD_BYTES) + 1;
   localparam int unsigned WW    = WORD_BYTES * 8;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      WAIT,
      LOAD,
      DRAIN
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
   logic [LEN_W-1:0]  words_left_q, words_left_d;
   logic [WW-1:0]     asm_q, asm_d;
   logic [WW-1:0]     word_data_q, word_data_d;
   logic              word_valid_q, word_valid_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              accept;

   assign accept     = word_valid_q & word_ready;
   assign busy       = busy_q;
   assign done       = done_q;
   assign word_data  = word_data_q;
   assign word_valid = word_valid_q;

   always_comb begin
      state_d      = state_q;
      byte_cnt_d   = byte_cnt_q;
      words_left_d = words_left_q;
      asm_d        = asm_q;
      word_data_d  = word_data_q;
      word_valid_d = word_valid_q;
      busy_d       = busy_q;
      done_d       = 1'b0;
      rx_rd_en     = 1'b0;

      // A consumer handshake may land in any state; LOAD below may re-set valid.
      if (accept) begin
         word_valid_d = 1'b0;
      end

      case (state_q)
         IDLE: begin
            if (start) begin
               if (length != '0) begin
                  words_left_d = length;
                  byte_cnt_d   = '0;
                  busy_d       = 1'b1;
                  state_d      = REQ;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         REQ: begin
            rx_rd_en = 1'b1;
            state_d  = WAIT;
         end
         WAIT: begin
            if (rx_received) begin
               for (int unsigned i = 0; i < WORD_BYTES; i++) begin
                  if (byte_cnt_q == CNT_W'(i)) begin
                     asm_d[(WORD_BYTES-1-i)*8 +: 8] = rx_data;
                  end
               end
               if (byte_cnt_q < CNT_W'(WORD_BYTES-1)) begin
                  byte_cnt_d = byte_cnt_q + CNT_W'(1);
                  state_d    = REQ;
               end else begin
                  state_d = LOAD;
               end
            end
         end
         LOAD: begin
            if (!word_valid_q || word_ready) begin
               word_data_d  = asm_q;
               word_valid_d = 1'b1;
               words_left_d = words_left_q - LEN_W'(1);
               byte_cnt_d   = '0;
               state_d      = (words_left_q == LEN_W'(1)) ? DRAIN : REQ;
            end
         end
         DRAIN: begin
            if (accept) begin
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         byte_cnt_q   <= '0;
         words_left_q <= '0;
         asm_q        <= '0;
         word_data_q  <= '0;
         word_valid_q <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         byte_cnt_q   <= byte_cnt_d;
         words_left_q <= words_left_d;
         asm_q        <= asm_d;
         word_data_q  <= word_data_d;
         word_valid_q <= word_valid_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

endmodule

// File: tb/tb_spi_rx_word_reader.sv
// Bench for spi_rx_word_reader: a 2-byte-word and a 1-byte-word instance, each
// fed by a byte receiver model; words are checked against packed source bytes.
`timescale 1ns/1ps
module tb_spi_rx_word_reader;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;

   logic        start_a, busy_a, done_a, rd_a, wv_a, wr_a;
   logic [7:0]  length_a;
   logic [7:0]  rxd_a  = 8'h00;
   logic        recv_a = 1'b0;
   logic [15:0] wd_a;

   logic        start_b, busy_b, done_b, rd_b, wv_b, wr_b;
   logic [7:0]  length_b;
   logic [7:0]  rxd_b  = 8'h00;
   logic        recv_b = 1'b0;
   logic [7:0]  wd_b;

   spi_rx_word_reader #(.WORD_BYTES(2), .LEN_W(8)) dut_a (
      .clk(clk), .rst_n(rst_n), .start(start_a), .length(length_a),
      .busy(busy_a), .done(done_a), .rx_rd_en(rd_a), .rx_data(rxd_a),
      .rx_received(recv_a), .word_data(wd_a), .word_valid(wv_a), .word_ready(wr_a)
   );

   spi_rx_word_reader #(.WORD_BYTES(1), .LEN_W(8)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(start_b), .length(length_b),
      .busy(busy_b), .done(done_b), .rx_rd_en(rd_b), .rx_data(rxd_b),
      .rx_received(recv_b), .word_data(wd_b), .word_valid(wv_b), .word_ready(wr_b)
   );

   int n_assert = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Byte receiver models: completion pulse lat cycles after a request is seen.
   int          lat_a = 2, pend_a = 0;
   int          lat_b = 1, pend_b = 0;
   logic [7:0]  feed_a[$];
   logic [7:0]  feed_b[$];

   always begin
      @(posedge clk);
      #1;
      recv_a = 1'b0;
      if (pend_a > 0) begin
         pend_a--;
         if (pend_a == 0) begin
            recv_a = 1'b1;
            rxd_a  = (feed_a.size() > 0) ? feed_a.pop_front() : 8'hEE;
         end
      end
      if (rd_a) pend_a = lat_a;
   end

   always begin
      @(posedge clk);
      #1;
      recv_b = 1'b0;
      if (pend_b > 0) begin
         pend_b--;
         if (pend_b == 0) begin
            recv_b = 1'b1;
            rxd_b  = (feed_b.size() > 0) ? feed_b.pop_front() : 8'hEE;
         end
      end
      if (rd_b) pend_b = lat_b;
   end

   // Stream monitors sampled mid-cycle.
   int          cyc = 0;
   int          rd_cnt_a = 0, done_cnt_a = 0, last_hs_cyc_a = 0, done_cyc_a = 0;
   int          rd_cnt_b = 0, done_cnt_b = 0, last_recv_cyc_b = 0;
   logic [15:0] got_a[$];
   logic [7:0]  got_b[$];
   logic [15:0] exp_a[$];
   logic [7:0]  exp_b[$];
   logic        prev_rd_a = 1'b0, prev_v_a = 1'b0, prev_hs_a = 1'b0;
   logic        prev_rd_b = 1'b0, prev_v_b = 1'b0;
   logic [15:0] prev_d_a = '0;

   always @(negedge clk) begin
      cyc++;
      if (rd_a) begin
         rd_cnt_a++;
         check("rd_en_width_a", prev_rd_a, 1'b0);
         check("rd_en_vs_recv_a", recv_a, 1'b0);
      end
      if (done_a) begin
         done_cnt_a++;
         done_cyc_a = cyc;
      end
      if (rst_n && prev_v_a && !prev_hs_a) begin
         check("hold_valid_a", wv_a, 1'b1);
         check("hold_data_a", wd_a, prev_d_a);
      end
      if (wv_a && wr_a) begin
         got_a.push_back(wd_a);
         last_hs_cyc_a = cyc;
      end
      prev_rd_a = rd_a;
      prev_v_a  = wv_a;
      prev_hs_a = wv_a & wr_a;
      prev_d_a  = wd_a;

      if (rd_b) begin
         rd_cnt_b++;
         check("rd_en_width_b", prev_rd_b, 1'b0);
         check("rd_en_vs_recv_b", recv_b, 1'b0);
      end
      if (done_b) done_cnt_b++;
      if (recv_b) last_recv_cyc_b = cyc;
      if (rst_n && wv_b && !prev_v_b) check("recv_to_valid_b", cyc - last_recv_cyc_b, 2);
      if (wv_b && wr_b) got_b.push_back(wd_b);
      prev_rd_b = rd_b;
      prev_v_b  = wv_b;
   end

   task automatic clear_a();
      rd_cnt_a = 0;
      done_cnt_a = 0;
      got_a.delete();
      exp_a.delete();
   endtask

   // Random source bytes; each expected word is its bytes concatenated in order.
   task automatic load_bytes_a(input int nwords);
      logic [15:0] w;
      logic [7:0]  v;
      for (int i = 0; i < nwords; i++) begin
         w = '0;
         for (int j = 0; j < 2; j++) begin
            v = 8'($urandom_range(0, 255));
            feed_a.push_back(v);
            w = {w[7:0], v};
         end
         exp_a.push_back(w);
      end
   endtask

   task automatic pulse_start_a(input int len);
      start_a  = 1'b1;
      length_a = 8'(len);
      step();
      start_a  = 1'b0;
      length_a = '0;
   endtask

   task automatic wait_done_a(input string tag, input int budget, input bit rand_ready);
      int n;
      n = 0;
      while (!done_a && n < budget) begin
         if (rand_ready) wr_a = 1'($urandom_range(0, 1));
         step();
         n++;
      end
      check(tag, done_a, 1'b1);
      wr_a = 1'b1;
   endtask

   task automatic check_words_a(input string tag);
      check({tag, "_count"}, got_a.size(), exp_a.size());
      for (int i = 0; i < exp_a.size(); i++) begin
         check({tag, "_word"}, (i < got_a.size()) ? got_a[i] : 16'hxxxx, exp_a[i]);
      end
   endtask

   initial begin
      int len;
      int n;

      rst_n = 1'b0;
      start_a = 1'b0; length_a = '0; wr_a = 1'b0;
      start_b = 1'b0; length_b = '0; wr_b = 1'b1;
      repeat (3) step();

      check("rst_busy_a", busy_a, 1'b0);
      check("rst_done_a", done_a, 1'b0);
      check("rst_rd_a", rd_a, 1'b0);
      check("rst_valid_a", wv_a, 1'b0);
      check("rst_data_a", wd_a, 16'h0000);
      check("rst_busy_b", busy_b, 1'b0);
      check("rst_valid_b", wv_b, 1'b0);
      check("rst_data_b", wd_b, 8'h00);

      rst_n = 1'b1;
      step();

      // Basic read of two words with the consumer always ready.
      clear_a();
      lat_a = 2;
      wr_a  = 1'b1;
      feed_a.push_back(8'h12); feed_a.push_back(8'h34);
      feed_a.push_back(8'h56); feed_a.push_back(8'h78);
      exp_a.push_back(16'h1234); exp_a.push_back(16'h5678);
      pulse_start_a(2);
      check("start_to_rd_a", rd_a, 1'b1);
      check("busy_after_start_a", busy_a, 1'b1);
      wait_done_a("basic_done", 200, 1'b0);
      step();
      check("basic_busy_clear", busy_a, 1'b0);
      check("basic_done_width", done_a, 1'b0);
      check("basic_done_after_hs", done_cyc_a - last_hs_cyc_a, 1);
      check("basic_rd_count", rd_cnt_a, 4);
      check("basic_done_count", done_cnt_a, 1);
      check_words_a("basic");

      // Backpressure: first word held for 40 cycles while the next assembles.
      clear_a();
      load_bytes_a(3);
      wr_a = 1'b0;
      pulse_start_a(3);
      n = 0;
      while (!wv_a && n < 100) begin
         step();
         n++;
      end
      check("bp_first_valid", wv_a, 1'b1);
      repeat (40) step();
      check("bp_data_held", wd_a, exp_a[0]);
      check("bp_still_valid", wv_a, 1'b1);
      check("bp_rd_count_stalled", rd_cnt_a, 4);
      check("bp_no_handshake", got_a.size(), 0);
      wr_a = 1'b1;
      wait_done_a("bp_done", 200, 1'b0);
      step();
      check("bp_rd_count", rd_cnt_a, 6);
      check("bp_done_count", done_cnt_a, 1);
      check_words_a("bp");

      // Zero length: immediate done, never busy, no requests.
      clear_a();
      pulse_start_a(0);
      check("zero_done", done_a, 1'b1);
      check("zero_busy", busy_a, 1'b0);
      check("zero_rd", rd_a, 1'b0);
      step();
      check("zero_done_width", done_a, 1'b0);
      check("zero_busy_after", busy_a, 1'b0);
      repeat (3) step();
      check("zero_rd_count", rd_cnt_a, 0);
      check("zero_done_count", done_cnt_a, 1);

      // A second start while busy must be ignored.
      clear_a();
      load_bytes_a(2);
      pulse_start_a(2);
      repeat (3) step();
      pulse_start_a(5);
      wait_done_a("sib_done", 200, 1'b0);
      repeat (12) step();
      check("sib_busy_clear", busy_a, 1'b0);
      check("sib_rd_count", rd_cnt_a, 4);
      check("sib_done_count", done_cnt_a, 1);
      check_words_a("sib");

      // Random lengths, receiver latencies and consumer readiness.
      for (int t = 0; t < 5; t++) begin
         clear_a();
         len   = int'($urandom_range(1, 6));
         lat_a = int'($urandom_range(1, 3));
         load_bytes_a(len);
         pulse_start_a(len);
         wait_done_a("rand_done", 600, 1'b1);
         step();
         check("rand_rd_count", rd_cnt_a, 2 * len);
         check("rand_done_count", done_cnt_a, 1);
         check_words_a("rand");
      end

      // Single-byte words with a one-cycle receiver.
      lat_b = 1;
      exp_b.delete();
      for (int i = 0; i < 6; i++) begin
         exp_b.push_back(8'($urandom_range(0, 255)));
         feed_b.push_back(exp_b[i]);
      end
      start_b  = 1'b1;
      length_b = 8'd6;
      step();
      start_b  = 1'b0;
      length_b = '0;
      check("start_to_rd_b", rd_b, 1'b1);
      n = 0;
      while (!done_b && n < 200) begin
         step();
         n++;
      end
      check("b_done", done_b, 1'b1);
      step();
      check("b_busy_clear", busy_b, 1'b0);
      check("b_rd_count", rd_cnt_b, 6);
      check("b_done_count", done_cnt_b, 1);
      check("b_word_count", got_b.size(), 6);
      for (int i = 0; i < 6; i++) begin
         check("b_word", (i < got_b.size()) ? got_b[i] : 8'hxx, exp_b[i]);
      end

      // Reset during the first word's byte wait; the late byte must be ignored.
      clear_a();
      feed_a.delete();
      lat_a = 4;
      load_bytes_a(3);
      pulse_start_a(3);
      step();
      rst_n = 1'b0;
      step();
      check("mid_rst_busy", busy_a, 1'b0);
      check("mid_rst_rd", rd_a, 1'b0);
      check("mid_rst_valid", wv_a, 1'b0);
      check("mid_rst_data", wd_a, 16'h0000);
      check("mid_rst_done", done_a, 1'b0);
      rst_n = 1'b1;
      repeat (8) step();
      check("post_rst_busy", busy_a, 1'b0);
      check("post_rst_valid", wv_a, 1'b0);
      check("post_rst_data", wd_a, 16'h0000);
      check("post_rst_rd_count", rd_cnt_a, 1);
      check("post_rst_done_count", done_cnt_a, 0);
      clear_a();
      feed_a.delete();
      load_bytes_a(1);
      pulse_start_a(1);
      wait_done_a("fresh_done", 200, 1'b0);
      step();
      check("fresh_rd_count", rd_cnt_a, 2);
      check_words_a("fresh");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
